// File: rtl/mem_arbiter_ctrl.sv
// Unified memory port arbiter (data before fetch) and global pipeline advance enable.
// Optional stall counter built only when MEM_ARB_STALL_CNT_EN is defined.
module mem_arbiter_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] d_rdata,
    output logic              pipe_en,
    output logic              err,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              d_done_q, d_done_d;
    logic              i_done_q, i_done_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              issue;
    logic              advance;
    logic              d_req;

    assign d_req = d_rd | d_wr;

    always_comb begin
        state_d   = state_q;
        d_done_d  = d_done_q;
        i_done_d  = i_done_q;
        instr_d   = instr_q;
        d_rdata_d = d_rdata_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        issue     = 1'b0;
        advance   = 1'b0;
        err_d     = err_q | (d_rd & d_wr);
        case (state_q)
            ARB: begin
                if (d_req && !d_done_q) begin
                    issue   = 1'b1;
                    wr_d    = d_wr;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = DWAIT;
                end else if (!i_done_q) begin
                    issue   = 1'b1;
                    wr_d    = 1'b0;
                    addr_d  = pc;
                    state_d = IWAIT;
                end else begin
                    advance  = 1'b1;
                    d_done_d = 1'b0;
                    i_done_d = 1'b0;
                end
            end
            DWAIT: begin
                if (mem_valid) begin
                    // Store acknowledges must not disturb the last load result.
                    if (!wr_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_done_d = 1'b1;
                    state_d  = ARB;
                end
            end
            IWAIT: begin
                if (mem_valid) begin
                    instr_d  = mem_rdata;
                    i_done_d = 1'b1;
                    state_d  = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB;
            d_done_q  <= 1'b0;
            i_done_q  <= 1'b0;
            instr_q   <= '0;
            d_rdata_q <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_done_q  <= d_done_d;
            i_done_q  <= i_done_d;
            instr_q   <= instr_d;
            d_rdata_q <= d_rdata_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    // Issue-cycle values go straight out; the held copies cover the wait states.
    assign mem_en    = issue & rst;
    assign pipe_en   = advance & rst;
    assign mem_wr    = mem_en ? wr_d    : wr_q;
    assign mem_addr  = mem_en ? addr_d  : addr_q;
    assign mem_wdata = mem_en ? wdata_d : wdata_q;
    assign instr     = instr_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;

`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (!advance && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl with a cycle-accurate memory responder and result scoreboard.
module tb_mem_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc, d_addr, d_wdata, mem_rdata;
    logic        d_rd, d_wr, mem_valid;
    logic        mem_en, mem_wr, pipe_en, err;
    logic [15:0] mem_addr, mem_wdata, instr, d_rdata, stall_cnt;

    always #5 clk = ~clk;

    mem_arbiter_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .pc(pc), .d_rd(d_rd), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .instr(instr), .d_rdata(d_rdata),
        .pipe_en(pipe_en), .err(err), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] drd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc;
    logic [15:0] m_drd;
    logic        m_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Entered at the sample point of the issue cycle; leaves at the sample point after completion.
    task automatic do_access(input string tag, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input int lat, input logic [15:0] rdata);
        chk({tag, "_issue_en"}, {15'd0, mem_en}, 16'd1);
        chk({tag, "_issue_wr"}, {15'd0, mem_wr}, {15'd0, wr});
        chk({tag, "_issue_addr"}, mem_addr, addr);
        if (wr) chk({tag, "_issue_wdata"}, mem_wdata, wdata);
        chk({tag, "_issue_pipe"}, {15'd0, pipe_en}, 16'd0);
        for (int k = 1; k <= lat; k++) begin
            next_cyc();
            mem_valid = (k == lat);
            mem_rdata = rdata;
            sample();
            chk({tag, "_wait_en"}, {15'd0, mem_en}, 16'd0);
            chk({tag, "_wait_wr"}, {15'd0, mem_wr}, {15'd0, wr});
            chk({tag, "_wait_addr"}, mem_addr, addr);
            if (wr) chk({tag, "_wait_wdata"}, mem_wdata, wdata);
            chk({tag, "_wait_pipe"}, {15'd0, pipe_en}, 16'd0);
        end
        next_cyc();
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        sample();
    endtask

    // Entered just after the edge that starts the step; leaves just after the pipe_en edge.
    task automatic run_step(input string tag, input logic rd, input logic wr,
                            input logic [15:0] p, input logic [15:0] da, input logic [15:0] dw,
                            input int lat, input logic [15:0] d_mem, input logic [15:0] i_mem);
        exp_t        e;
        logic [15:0] sc0;
        int          exp_cyc;
        pc      = p;
        d_rd    = rd;
        d_wr    = wr;
        d_addr  = da;
        d_wdata = dw;
        cyc     = 0;
        if (rd && !wr) m_drd = d_mem;
        if (rd && wr) m_err = 1'b1;
        e.instr = i_mem;
        e.drd   = m_drd;
        e.err   = m_err;
        sb.push_back(e);
        exp_cyc = (rd | wr) ? 2 * (lat + 1) : lat + 1;
        sample();
        sc0 = stall_cnt;
        if (rd | wr) do_access({tag, "_d"}, wr, da, dw, lat, d_mem);
        do_access({tag, "_i"}, 1'b0, p, 16'h0000, lat, i_mem);
        chk({tag, "_pipe_en"}, {15'd0, pipe_en}, 16'd1);
        chk({tag, "_pipe_cycle"}, 16'(cyc), 16'(exp_cyc));
        e = sb.pop_front();
        chk({tag, "_instr"}, instr, e.instr);
        chk({tag, "_d_rdata"}, d_rdata, e.drd);
        chk({tag, "_err"}, {15'd0, err}, {15'd0, e.err});
`ifdef MEM_ARB_STALL_CNT_EN
        chk({tag, "_stall_delta"}, stall_cnt - sc0, 16'(exp_cyc));
`else
        chk({tag, "_stall_tied"}, stall_cnt, 16'h0000);
`endif
        next_cyc();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_en"}, {15'd0, mem_en}, 16'd0);
        chk({tag, "_pipe_en"}, {15'd0, pipe_en}, 16'd0);
        chk({tag, "_instr"}, instr, 16'h0000);
        chk({tag, "_d_rdata"}, d_rdata, 16'h0000);
        chk({tag, "_err"}, {15'd0, err}, 16'd0);
        chk({tag, "_stall"}, stall_cnt, 16'h0000);
        chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
        chk({tag, "_mem_wr"}, {15'd0, mem_wr}, 16'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
    endtask

    initial begin
        rst       = 1'b0;
        pc        = 16'h0010;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        d_addr    = 16'h0000;
        d_wdata   = 16'h0000;
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        m_drd     = 16'h0000;
        m_err     = 1'b0;
        sample();
        sample();
        chk_reset("por");

        @(posedge clk);
        #1;
        rst = 1'b1;
        run_step("fetch", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h0000, 16'hA123);
        run_step("load",  1'b1, 1'b0, 16'h0012, 16'h0040, 16'h0000, 1, 16'h5555, 16'h1111);
        run_step("store", 1'b0, 1'b1, 16'h0014, 16'h0080, 16'hBEEF, 3, 16'h0BAD, 16'h2222);
        run_step("both",  1'b1, 1'b1, 16'h0016, 16'h0090, 16'hCAFE, 1, 16'h0F0F, 16'h3333);
        run_step("sticky_ld", 1'b1, 1'b0, 16'h0018, 16'h00A0, 16'h0000, 2, 16'h6789, 16'h4444);
        run_step("sticky_if", 1'b0, 1'b0, 16'h001A, 16'h0000, 16'h0000, 1, 16'h0000, 16'h5656);

        // Abort a fetch mid-wait, then offer a stray completion right after release.
        pc   = 16'h0020;
        d_rd = 1'b0;
        d_wr = 1'b0;
        sample();
        chk("abort_issue_en", {15'd0, mem_en}, 16'd1);
        next_cyc();
        rst = 1'b0;
        #1;
        chk_reset("abort");
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 16'hDEAD;
        cyc       = 0;
        sample();
        do_access("rst_i", 1'b0, 16'h0020, 16'h0000, 3, 16'h7777);
        chk("rst_pipe_en", {15'd0, pipe_en}, 16'd1);
        chk("rst_pipe_cycle", 16'(cyc), 16'd4);
        chk("rst_instr", instr, 16'h7777);
        chk("rst_d_rdata", d_rdata, 16'h0000);
        chk("rst_err", {15'd0, err}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter_ctrl.md
# mem_arbiter_ctrl

Shared-memory arbiter and pipeline stall controller for the 16-bit five-stage core. It multiplexes a single unified memory port between instruction fetch (PC) and data access (MemRead/MemWrite, address and store data from the EX/MEM latch). It also generates the one global enable that advances the PC and every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB). The pipeline advances exactly one step after all memory traffic for the current step has completed.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data/instruction width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- pc  in  ADDR_W  fetch address from PC register
- d_rd  in  1  data load request (EX/MEM MemRead)
- d_wr  in  1  data store request (EX/MEM MemWrite)
- d_addr  in  ADDR_W  data address (EX/MEM ALU result)
- d_wdata  in  DATA_W  store data (EX/MEM B operand)
- mem_en  out  1  request strobe to memory, one cycle per access
- mem_wr  out  1  1 = write, 0 = read; valid with mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_valid  in  1  memory completion: read data valid or write acknowledged
- mem_rdata  in  DATA_W  memory read data
- instr  out  DATA_W  fetched instruction, held until next fetch completes
- d_rdata  out  DATA_W  load data, held until next load completes
- pipe_en  out  1  global advance enable for PC and all pipeline latches
- err  out  1  sticky: d_rd and d_wr were seen together
- stall_cnt  out  16  stall-cycle counter (see Configuration)

## Operation
- States: ARB, DWAIT, IWAIT. Internal flags: d_done, i_done.
- d_req = d_rd | d_wr. If both are high, the access is a write and err is set. err stays set until rst.
- ARB:
  - If d_req and !d_done: issue the data access (mem_en=1, mem_wr=d_wr, mem_addr=d_addr, mem_wdata=d_wdata) and go to DWAIT.
  - Else if !i_done: issue the fetch (mem_en=1, mem_wr=0, mem_addr=pc) and go to IWAIT.
  - Else: pipe_en=1, clear d_done and i_done, and stay in ARB.
- Data has strict priority over fetch within a step.
- DWAIT: on mem_valid, capture mem_rdata into d_rdata (loads only), set d_done, go to ARB. Otherwise hold.
- IWAIT: on mem_valid, capture mem_rdata into instr, set i_done, go to ARB. Otherwise hold.
- mem_addr, mem_wr and mem_wdata are registered at issue and held stable through the wait state. mem_en is high only in the issue cycle.
- mem_valid is ignored in ARB; a stray completion is dropped.
- pipe_en is 0 in every cycle except the final ARB cycle of a step.

## Timing
- Reset (rst=0, asynchronous): state=ARB, d_done=i_done=0, instr=0x0000, d_rdata=0x0000, err=0, stall_cnt=0, held mem_* registers=0. While rst=0, mem_en=0 and pipe_en=0.
- First cycle after reset release: fetch issued at pc.
- Zero-wait memory (mem_valid in the cycle after mem_en):
  - Fetch-only step: 3 cycles (issue, wait, advance).
  - Load/store step: 5 cycles (D issue, D wait, I issue, I wait, advance).
- N-cycle memory adds N-1 cycles per access.
- d_rdata and instr are valid from the cycle after their capture through the pipe_en cycle, so the MEM/WB and IF/ID latches capture the correct value on the pipe_en edge.
- Pipeline inputs (pc, d_*) are stable between pipe_en pulses, because all latches are frozen.
- Reset asserted mid-access aborts the access immediately. Any late mem_valid after release is dropped in ARB.

## Configuration
- MEM_ARB_STALL_CNT_EN defined: stall_cnt increments by 1 on every cycle with rst=1 and pipe_en=0. It saturates at 0xFFFF and resets to 0 on rst.
- MEM_ARB_STALL_CNT_EN undefined: stall_cnt is tied to 0x0000 and no counter logic is built.

## Test plan
- Reset, then fetch-only at pc=0x0010, mem_valid one cycle after mem_en with rdata=0xA123 -> mem_en/mem_addr=0x0010 at cycle 0, instr=0xA123 at cycle 2, pipe_en=1 only at cycle 2, next fetch at cycle 3.
- d_rd=1, d_addr=0x0040, rdata 0x5555 then fetch rdata 0x1111 -> data issued before fetch, d_rdata=0x5555, instr=0x1111, pipe_en at cycle 4.
- d_wr=1, d_addr=0x0080, d_wdata=0xBEEF, memory latency 3 -> mem_wr=1 and address/data held 3 cycles, d_rdata unchanged, pipe_en at cycle 8, stall_cnt=8 with the macro defined.
- d_rd=d_wr=1 -> write performed, err=1 and remains set across later steps until rst=0.
- rst pulsed low during IWAIT, then mem_valid one cycle after release -> outputs at reset values, stray mem_valid ignored, fresh fetch issued, no pipe_en until it completes.
